// File: rtl/shift_seq_ctrl_if.sv
// shift_seq_ctrl_if
//   Request/result bundle between the ALU issue logic (master) and the
//   multi-pass shift sequencer (slave).
//
//   Handshake: the master raises start with din/amt/lr/al valid; the request
//   is accepted at the rising edge where start=1 and ready=1. While busy=1,
//   start and the operand fields are ignored. Completion is marked by a
//   one-cycle done pulse. result is valid from that cycle and holds until the
//   next accepted request completes.
//
//   Signals: start, din[7:0], amt[AMT_W-1:0], lr, al  (master -> slave)
//            ready, busy, done, result[7:0]           (slave -> master)
interface shift_seq_ctrl_if #(
    parameter int AMT_W = 5
);
    logic             start;
    logic [7:0]       din;
    logic [AMT_W-1:0] amt;
    logic             lr;
    logic             al;
    logic             ready;
    logic             busy;
    logic             done;
    logic [7:0]       result;

    modport master (
        output start, din, amt, lr, al,
        input  ready, busy, done, result
    );

    modport slave (
        input  start, din, amt, lr, al,
        output ready, busy, done, result
    );
endinterface

// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl
//   Multi-pass shift sequencer. A registered accumulator is fed through one
//   8-bit barrel shifter repeatedly, at most MAX_STEP positions per pass,
//   so total shift amounts up to 2^AMT_W-1 are supported.
//
//   Ports:
//     clk         rising-edge clock
//     rst_n       asynchronous active-low reset
//     bus         shift_seq_ctrl_if.slave (start/din/amt/lr/al in,
//                 ready/busy/done/result out)
//     dbg_state_o current FSM state (0=IDLE, 1=RUN)
//
//   barrel_shifter8
//     din[7:0], shamt[2:0], LR (1=left), AL (1=arithmetic right) -> dout[7:0]

module barrel_shifter8 (
    input  logic [7:0] din,
    input  logic [2:0] shamt,
    input  logic       LR,
    input  logic       AL,
    output logic [7:0] dout
);
    always_comb begin
        if (LR) begin
            dout = din << shamt;
        end else if (AL) begin
            dout = 8'($signed(din) >>> shamt);
        end else begin
            dout = din >> shamt;
        end
    end
endmodule

module shift_seq_ctrl #(
    parameter int AMT_W    = 5,
    parameter int MAX_STEP = 7
) (
    input  logic                 clk,
    input  logic                 rst_n,
    shift_seq_ctrl_if.slave      bus,
    output logic                 dbg_state_o
);
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam logic [AMT_W-1:0] MAX_STEP_W = AMT_W'(MAX_STEP);
    localparam logic [2:0]       MAX_STEP_3 = 3'(MAX_STEP);

    logic [0:0]       state_q;
    logic [7:0]       acc_q;
    logic [AMT_W-1:0] rem_q;
    logic             lr_q;
    logic             al_q;
    logic [7:0]       result_q;
    logic             done_q;

    logic [2:0]       step;
    logic [AMT_W-1:0] rem_d;
    logic [7:0]       shift_out;

    // step never exceeds rem, so rem_d cannot wrap below zero.
    always_comb begin
        step  = (rem_q > MAX_STEP_W) ? MAX_STEP_3 : rem_q[2:0];
        rem_d = rem_q - AMT_W'(step);
    end

    barrel_shifter8 u_shifter (
        .din   (acc_q),
        .shamt (step),
        .LR    (lr_q),
        .AL    (al_q),
        .dout  (shift_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            acc_q    <= 8'h00;
            rem_q    <= '0;
            lr_q     <= 1'b0;
            al_q     <= 1'b0;
            result_q <= 8'h00;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        // amt==0 still takes one pass with step 0, so the
                        // latency is uniformly at least one cycle.
                        acc_q   <= bus.din;
                        rem_q   <= bus.amt;
                        lr_q    <= bus.lr;
                        al_q    <= bus.al;
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    acc_q <= shift_out;
                    rem_q <= rem_d;
                    if (rem_d == '0) begin
                        state_q  <= S_IDLE;
                        result_q <= shift_out;
                        done_q   <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.ready   = (state_q == S_IDLE);
    assign bus.busy    = (state_q == S_RUN);
    assign bus.done    = done_q;
    assign bus.result  = result_q;
    assign dbg_state_o = state_q[0];
endmodule

// File: tb/tb_shift_seq_ctrl.sv
module tb_shift_seq_ctrl;
  localparam int AMT_W    = 5;
  localparam int MAX_STEP = 7;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  logic dbg_state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  shift_seq_ctrl_if #(.AMT_W(AMT_W)) bus ();

  shift_seq_ctrl #(.AMT_W(AMT_W), .MAX_STEP(MAX_STEP)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  int errors;
  int checks;
  int done_cnt;

  always @(negedge clk) if (bus.done === 1'b1) done_cnt++;

  // ---------------- reference model ----------------
  // Bit-by-bit view of a single shift by the full amount.
  function automatic logic [7:0] ref_shift(input logic [7:0] d, input int a,
                                           input bit l, input bit ar);
    logic [7:0] r;
    int s;
    for (int i = 0; i < 8; i++) begin
      if (l) begin
        s = i - a;
        r[i] = (s >= 0) ? d[s] : 1'b0;
      end else begin
        s = i + a;
        r[i] = (s < 8) ? d[s] : (ar ? d[7] : 1'b0);
      end
    end
    return r;
  endfunction

  function automatic int ref_passes(input int a);
    return (a == 0) ? 1 : (a + MAX_STEP - 1) / MAX_STEP;
  endfunction

  // ---------------- driver tasks ----------------
  // Called at a negedge: present a request for the next rising edge.
  task automatic drive_req(input logic [7:0] d, input int a, input bit l,
                           input bit ar, input string name);
    checks++;
    if (bus.ready !== 1'b1) begin
      errors++;
      $display("FAIL %s ready_at_start: got %b want 1", name, bus.ready);
    end
    bus.start = 1'b1;
    bus.din   = d;
    bus.amt   = AMT_W'(a);
    bus.lr    = l;
    bus.al    = ar;
  endtask

  // Waits for done after drive_req; optionally sprays ignored starts while busy.
  task automatic wait_done(input logic [7:0] exp_res, input int exp_p,
                           input bit inject, input string name);
    int cnt;
    int busy_cnt;
    bit seen;
    cnt = 0;
    busy_cnt = 0;
    seen = 0;
    while (!seen && cnt < exp_p + 20) begin
      @(negedge clk);
      cnt++;
      if (bus.done === 1'b1) seen = 1;
      else if (bus.busy === 1'b1) busy_cnt++;
      if (!seen && inject && bus.busy === 1'b1 && $urandom_range(0, 1) == 1) begin
        bus.start = 1'b1;
        bus.din   = 8'($urandom);
        bus.amt   = AMT_W'($urandom);
        bus.lr    = 1'($urandom);
        bus.al    = 1'($urandom);
      end else begin
        bus.start = 1'b0;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s done_timeout: got no done within %0d cycles want %0d", name, cnt, exp_p);
      return;
    end
    checks++;
    if (cnt - 1 != exp_p) begin
      errors++;
      $display("FAIL %s latency: got %0d want %0d", name, cnt - 1, exp_p);
    end
    checks++;
    if (busy_cnt != exp_p) begin
      errors++;
      $display("FAIL %s busy_cycles: got %0d want %0d", name, busy_cnt, exp_p);
    end
    checks++;
    if (bus.result !== exp_res) begin
      errors++;
      $display("FAIL %s result: got %02h want %02h", name, bus.result, exp_res);
    end
    checks++;
    if (bus.ready !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL %s done_state: got ready=%b busy=%b want ready=1 busy=0", name, bus.ready, bus.busy);
    end
  endtask

  task automatic check_pulse_end(input logic [7:0] exp_res, input string name);
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0) begin
      errors++;
      $display("FAIL %s done_width: got done=%b want 0", name, bus.done);
    end
    checks++;
    if (bus.result !== exp_res) begin
      errors++;
      $display("FAIL %s result_hold: got %02h want %02h", name, bus.result, exp_res);
    end
  endtask

  task automatic run_op(input logic [7:0] d, input int a, input bit l,
                        input bit ar, input bit inject, input string name);
    logic [7:0] exp_res;
    exp_res = ref_shift(d, a, l, ar);
    drive_req(d, a, l, ar, name);
    wait_done(exp_res, ref_passes(a), inject, name);
    check_pulse_end(exp_res, name);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    checks++;
    if (bus.ready !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs: got ready=%b busy=%b done=%b result=%02h want 1 0 0 00",
               bus.ready, bus.busy, bus.done, bus.result);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.ready !== 1'b1 || bus.done !== 1'b0 || bus.result !== 8'h00) begin
      errors++;
      $display("FAIL reset_release: got ready=%b done=%b result=%02h want 1 0 00",
               bus.ready, bus.done, bus.result);
    end
  endtask

  task automatic test_amt_zero;
    run_op(8'h96, 0, 1'b1, 1'b0, 1'b0, "amt_zero");
  endtask

  task automatic test_single_pass_right;
    run_op(8'hB4, 2, 1'b0, 1'b1, 1'b0, "sra2");
    run_op(8'hB4, 2, 1'b0, 1'b0, 1'b0, "srl2");
  endtask

  task automatic test_two_pass_right;
    run_op(8'h80, 10, 1'b0, 1'b1, 1'b0, "sra10");
    run_op(8'h80, 10, 1'b0, 1'b0, 1'b0, "srl10");
  endtask

  task automatic test_max_amt_ignored_start;
    run_op(8'hFF, 31, 1'b1, 1'b0, 1'b1, "sll31_inject");
    repeat (3) @(negedge clk);
    checks++;
    if (bus.result !== 8'h00 || bus.ready !== 1'b1) begin
      errors++;
      $display("FAIL sll31_after: got result=%02h ready=%b want 00 1", bus.result, bus.ready);
    end
  endtask

  task automatic test_back_to_back;
    int base;
    base = done_cnt;
    drive_req(8'h01, 3, 1'b1, 1'b0, "b2b_first");
    wait_done(ref_shift(8'h01, 3, 1'b1, 1'b0), ref_passes(3), 1'b0, "b2b_first");
    drive_req(8'h40, 9, 1'b0, 1'b0, "b2b_second");
    wait_done(ref_shift(8'h40, 9, 1'b0, 1'b0), ref_passes(9), 1'b0, "b2b_second");
    check_pulse_end(8'h00, "b2b_second");
    repeat (3) @(negedge clk);
    checks++;
    if (done_cnt - base != 2) begin
      errors++;
      $display("FAIL b2b_done_count: got %0d want 2", done_cnt - base);
    end
  endtask

  task automatic test_reset_mid_run;
    int base;
    run_op(8'h96, 0, 1'b0, 1'b0, 1'b0, "pre_reset");
    drive_req(8'h55, 20, 1'b1, 1'b0, "mid_reset");
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.ready !== 1'b1 || bus.done !== 1'b0 || bus.result !== 8'h00) begin
      errors++;
      $display("FAIL mid_reset_async: got busy=%b ready=%b done=%b result=%02h want 0 1 0 00",
               bus.busy, bus.ready, bus.done, bus.result);
    end
    @(negedge clk);
    rst_n = 1'b1;
    base = done_cnt;
    repeat (10) @(negedge clk);
    checks++;
    if (done_cnt != base || bus.result !== 8'h00 || bus.ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_after: got done_pulses=%0d result=%02h ready=%b want 0 00 1",
               done_cnt - base, bus.result, bus.ready);
    end
  endtask

  task automatic test_random;
    logic [7:0] exp_q[$];
    logic [7:0] d;
    int a;
    bit l;
    bit ar;
    for (int n = 0; n < 30; n++) begin
      d  = 8'($urandom);
      a  = $urandom_range(0, (1 << AMT_W) - 1);
      l  = 1'($urandom);
      ar = 1'($urandom);
      exp_q.push_back(ref_shift(d, a, l, ar));
      drive_req(d, a, l, ar, "random");
      wait_done(exp_q.pop_front(), ref_passes(a), 1'($urandom), "random");
    end
    bus.start = 1'b0;
    @(negedge clk);
  endtask

  // ---------------- main sequence / report ----------------
  initial begin
    errors    = 0;
    checks    = 0;
    done_cnt  = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.din   = 8'h00;
    bus.amt   = '0;
    bus.lr    = 1'b0;
    bus.al    = 1'b0;
    #1;
    test_reset;
    test_amt_zero;
    test_single_pass_right;
    test_two_pass_right;
    test_max_amt_ignored_start;
    test_back_to_back;
    test_random;
    test_reset_mid_run;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/shift_seq_ctrl.md
Name: shift_seq_ctrl

Overview:
- Multi-pass shift sequencer around one internal barrel_shifter8 instance. barrel_shifter8 is the 8-bit combinational shifter with ports din, shamt[2:0], LR, AL and dout.
- Extends the shift range from 0..7 to 0..(2^AMT_W - 1) by iterating the shifter over a registered accumulator, with at most MAX_STEP positions per cycle.
- Sits between ALU issue logic and the shifter, using a start/ready/done handshake.

Parameters:
AMT_W, 5, width of the requested shift amount.
MAX_STEP, 7, maximum positions per pass. Legal range 1..7.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst_n  input  1  asynchronous, active-low reset.
start  input  1  request strobe; sampled only when ready=1.
din  input  8  operand, latched on accept.
amt  input  AMT_W  total shift amount, latched on accept.
lr  input  1  direction, latched on accept: 1=left, 0=right.
al  input  1  arithmetic flag, latched on accept: 1=sign fill on right shift; ignored on left.
ready  output  1  high when a new request can be accepted (state IDLE).
busy  output  1  high while passes are outstanding (state RUN).
done  output  1  one-cycle pulse; result is valid from this cycle.
result  output  8  final shifted value, held until the next accepted request completes.

Behaviour:
- Reset (asynchronous, any state): state=IDLE, acc=0, rem=0, lr_q=0, al_q=0, result=0, done=0. Outputs are therefore ready=1 and busy=0.
- Registers: acc[7:0], rem[AMT_W-1:0], lr_q, al_q, state in {IDLE, RUN}.
- ready = (state==IDLE); busy = (state==RUN). Both are combinational from state.
- Accept: start=1 in IDLE at an edge. Then acc<=din, lr_q<=lr, al_q<=al, state<=RUN.
  - amt==0: rem<=0 and state<=RUN anyway. The single pass uses step 0 and returns din unchanged, so minimum latency is 1.
  - amt!=0: rem<=amt.
- Step, combinational: step = (rem > MAX_STEP) ? MAX_STEP : rem[2:0].
- Shifter connections: din=acc, shamt=step, LR=lr_q, AL=al_q.
- RUN, each edge:
  - acc<=shifter dout; rem<=rem-step.
  - If rem-step==0: state<=IDLE, result<=dout, done<=1.
  - Otherwise done<=0 and stay in RUN.
- done is 0 on every edge not covered above, so it is a single-cycle pulse.
- Latency from the accept edge to done high is P = max(1, ceil(amt/MAX_STEP)) cycles. Pass count is deterministic: no early exit when acc saturates to 0x00 or 0xFF.
- Shift semantics per pass:
  - left: fill 0.
  - right logical: fill 0.
  - right arithmetic: fill the current acc[7].
  - Composition of passes equals one shift by amt, including amt >= 8 (result 0x00, or 0xFF/0x00 for arithmetic by sign).
- Ignored inputs: start while busy is ignored; no queuing, no error flag. din, amt, lr and al changes during RUN have no effect.
- Back-to-back: in the done cycle state is IDLE and ready=1, so a start there is accepted. The next done pulse can occur P cycles later. result updates only on each completion.
- Reset during RUN aborts the operation: no done pulse is produced afterward, and result reads 0.
- rem never underflows because step <= rem by construction.
- amt at its maximum value (2^AMT_W - 1) must complete without wrap.

Test Plan:
1. din=0x96, amt=0, lr=1 -> done 1 cycle after accept; result=0x96; busy high exactly 1 cycle.
2. din=0xB4, amt=2, lr=0, al=1 -> done after 1 cycle; result=0xED. Repeat with al=0 -> result=0x2D.
3. din=0x80, amt=10, lr=0, al=1 -> 2 passes (step 7 then 3); done after 2 cycles; result=0xFF. Repeat with al=0 -> result=0x00.
4. din=0xFF, amt=31, lr=1 -> 5 passes (7,7,7,7,3); done after 5 cycles; result=0x00. Extra start pulses with different din during busy are ignored, and result is unchanged afterward.
5. Back-to-back requests:
   - First request: din=0x01, amt=3, lr=1 -> result=0x08.
   - Second request, start asserted in the done cycle: din=0x40, amt=9, lr=0, al=0. It is accepted (ready=1 that cycle) and gives result=0x00 after 2 cycles.
   - done must pulse exactly twice.
6. Reset mid-run: din=0x55, amt=20. Drive rst_n low asynchronously during pass 2 -> busy=0, ready=1, done=0, result=0x00 immediately, without waiting for a clock edge. After rst_n release, no done pulse occurs.
